// File: rtl/sha256_pkg.sv
// Shared SHA-256 front-end definitions: block geometry, padding constants, padder state.
package sha256_pkg;
  localparam int BLOCK_WIDTH     = 512;
  localparam int LEN_FIELD_WIDTH = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int LEN_SLOT_START  = 56;

  typedef enum logic [2:0] {IDLE, FILL, PAD, EMIT, LENBLK} pad_state_e;
endpackage

// File: rtl/sha256_msg_padder_if.sv
// Message-in / block-out bundle for the padder. Optional block_index under
// SHA256_PADDER_BLOCK_INDEX_EN.
interface sha256_msg_padder_if #(
  parameter int LEN_WIDTH    = 8,
  parameter int SYMBOL_WIDTH = 8
);
  import sha256_pkg::*;
  logic                    start;
  logic [LEN_WIDTH-1:0]    msg_length;
  logic                    msg_valid;
  logic [SYMBOL_WIDTH-1:0] msg_data;
  logic                    msg_ready;
  logic [BLOCK_WIDTH-1:0]  block;
  logic                    block_valid;
  logic                    block_ready;
  logic                    block_last;
  logic                    busy;
  logic                    done;
  logic                    length_err;
`ifdef SHA256_PADDER_BLOCK_INDEX_EN
  logic [1:0]              block_index;
  modport slave  (input  start, msg_length, msg_valid, msg_data, block_ready,
                  output msg_ready, block, block_valid, block_last, busy, done, length_err, block_index);
  modport master (output start, msg_length, msg_valid, msg_data, block_ready,
                  input  msg_ready, block, block_valid, block_last, busy, done, length_err, block_index);
`else
  modport slave  (input  start, msg_length, msg_valid, msg_data, block_ready,
                  output msg_ready, block, block_valid, block_last, busy, done, length_err);
  modport master (output start, msg_length, msg_valid, msg_data, block_ready,
                  input  msg_ready, block, block_valid, block_last, busy, done, length_err);
`endif
endinterface

// File: rtl/sha256_byte_insert.sv
// Combinational write of one byte into a 512-bit block; slot 0 is the MSB byte.
module sha256_byte_insert
  import sha256_pkg::*;
(
  input  logic [BLOCK_WIDTH-1:0] blk_i,
  input  logic [5:0]             ptr_i,
  input  logic [7:0]             byte_i,
  output logic [BLOCK_WIDTH-1:0] blk_o
);
  for (genvar i = 0; i < BLOCK_WIDTH/8; i++) begin : g_slot
    assign blk_o[BLOCK_WIDTH-1-8*i -: 8] = (ptr_i == 6'(i)) ? byte_i : blk_i[BLOCK_WIDTH-1-8*i -: 8];
  end
endmodule

// File: rtl/sha256_msg_padder.sv
// Streaming FIPS 180-4 padder: bytes in, one or two padded 512-bit blocks out.
// Define SHA256_PADDER_BLOCK_INDEX_EN to expose block_index.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int SYMBOL_WIDTH       = 8,
  parameter int MAX_MESSAGE_LENGTH = 119,
  parameter int LEN_WIDTH          = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
  input  logic clk,
  input  logic reset,
  sha256_msg_padder_if.slave bus
);
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert immediately, release two clocks later so no flop leaves reset mid-edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  pad_state_e                 state_q, state_d;
  logic [BLOCK_WIDTH-1:0]     block_q, block_d, ins_blk;
  logic [5:0]                 ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]       rem_q, rem_d;
  logic [LEN_FIELD_WIDTH-1:0] bit_len_q, bit_len_d;
  logic                       need_q, need_d;
  logic                       last_q, last_d;
  logic                       done_q, done_d;
  logic                       lerr_q, lerr_d;
  logic [SYMBOL_WIDTH-1:0]    ins_byte;
`ifdef SHA256_PADDER_BLOCK_INDEX_EN
  logic [1:0]                 idx_q, idx_d;
`endif

  sha256_byte_insert u_ins (.blk_i(block_q), .ptr_i(ptr_q), .byte_i(ins_byte), .blk_o(ins_blk));

  always_comb begin
    state_d   = state_q;
    block_d   = block_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    bit_len_d = bit_len_q;
    need_d    = need_q;
    last_d    = last_q;
    done_d    = 1'b0;
    lerr_d    = 1'b0;
`ifdef SHA256_PADDER_BLOCK_INDEX_EN
    idx_d     = idx_q;
`endif
    ins_byte  = (state_q == PAD) ? PAD_BYTE : bus.msg_data;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.msg_length > LEN_WIDTH'(MAX_MESSAGE_LENGTH)) begin
          lerr_d = 1'b1;
        end else begin
          rem_d     = bus.msg_length;
          bit_len_d = LEN_FIELD_WIDTH'(bus.msg_length) << 3;
          block_d   = '0;
          ptr_d     = '0;
          need_d    = 1'b0;
          last_d    = 1'b0;
`ifdef SHA256_PADDER_BLOCK_INDEX_EN
          idx_d     = '0;
`endif
          state_d   = (bus.msg_length == '0) ? PAD : FILL;
        end
      end
      FILL: if (bus.msg_valid) begin
        block_d = ins_blk;
        ptr_d   = ptr_q + 6'd1;
        rem_d   = rem_q - LEN_WIDTH'(1);
        // A full block is flushed first even on the final byte; PAD then starts a fresh one.
        if (ptr_q == 6'd63) begin
          last_d  = 1'b0;
          state_d = EMIT;
        end else if (rem_q == LEN_WIDTH'(1)) begin
          state_d = PAD;
        end
      end
      PAD: begin
        block_d = ins_blk;
        if (ptr_q < 6'(LEN_SLOT_START)) begin
          block_d[LEN_FIELD_WIDTH-1:0] = bit_len_q;
          last_d = 1'b1;
        end else begin
          last_d = 1'b0;
          need_d = 1'b1;
        end
        state_d = EMIT;
      end
      EMIT: if (bus.block_ready) begin
        block_d = '0;
        ptr_d   = '0;
`ifdef SHA256_PADDER_BLOCK_INDEX_EN
        idx_d   = idx_q + 2'd1;
`endif
        if (need_q)              state_d = LENBLK;
        else if (last_q)         begin state_d = IDLE; done_d = 1'b1; end
        else if (rem_q == '0)    state_d = PAD;
        else                     state_d = FILL;
      end
      LENBLK: begin
        block_d = BLOCK_WIDTH'(bit_len_q);
        last_d  = 1'b1;
        need_d  = 1'b0;
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      block_q   <= '0;
      ptr_q     <= '0;
      rem_q     <= '0;
      bit_len_q <= '0;
      need_q    <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      lerr_q    <= 1'b0;
`ifdef SHA256_PADDER_BLOCK_INDEX_EN
      idx_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      block_q   <= block_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      bit_len_q <= bit_len_d;
      need_q    <= need_d;
      last_q    <= last_d;
      done_q    <= done_d;
      lerr_q    <= lerr_d;
`ifdef SHA256_PADDER_BLOCK_INDEX_EN
      idx_q     <= idx_d;
`endif
    end
  end

  assign bus.msg_ready   = (state_q == FILL);
  assign bus.block       = block_q;
  assign bus.block_valid = (state_q == EMIT);
  assign bus.block_last  = last_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.length_err  = lerr_q;
`ifdef SHA256_PADDER_BLOCK_INDEX_EN
  assign bus.block_index = idx_q;
`endif
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed blocks plus a byte-level padding model.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha256_msg_padder_if #(.LEN_WIDTH(8), .SYMBOL_WIDTH(8)) bus();
  sha256_msg_padder #(.SYMBOL_WIDTH(8), .MAX_MESSAGE_LENGTH(119), .LEN_WIDTH(8))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int nchk = 0;
  int nerr = 0;
  logic [511:0] obs_blk [2];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_msg(input int L, input int stall, input logic [7:0] seed);
    logic [7:0]   pb [128];
    logic [7:0]   msg [128];
    logic [511:0] eb [2];
    logic [63:0]  bl;
    int nblk, total, sent, got, st, cyc, last_cyc, lat_v;
    nblk  = (L + 8) / 64 + 1;
    total = nblk * 64;
    bl    = 64'(L) * 64'd8;
    for (int i = 0; i < 128; i++) begin
      msg[i] = seed + 8'(i);
      pb[i]  = 8'h00;
    end
    for (int i = 0; i < L; i++) pb[i] = msg[i];
    pb[L] = 8'h80;
    for (int k = 0; k < 8; k++) pb[total-8+k] = bl[63-8*k -: 8];
    for (int b = 0; b < nblk; b++)
      for (int j = 0; j < 64; j++) eb[b][511-8*j -: 8] = pb[b*64+j];

    bus.start = 1'b1; bus.msg_length = 8'(L);
    @(negedge clk);
    bus.start = 1'b0;
    chk($sformatf("busy_L%0d", L), 512'(bus.busy), 512'(1));
    sent = 0; got = 0; st = 0; cyc = 0; last_cyc = -1; lat_v = -1;
    while (got < nblk && cyc < 3000) begin
      if (bus.block_valid) begin
        if (sent == L && lat_v < 0) lat_v = cyc;
        chk($sformatf("blk%0d_L%0d", got, L), bus.block, eb[got]);
        chk($sformatf("last%0d_L%0d", got, L), 512'(bus.block_last), 512'(got == nblk - 1));
        chk($sformatf("mrdy_emit_L%0d", L), 512'(bus.msg_ready), 512'(0));
`ifdef SHA256_PADDER_BLOCK_INDEX_EN
        chk($sformatf("idx%0d_L%0d", got, L), 512'(bus.block_index), 512'(got));
`endif
        bus.block_ready = (st >= stall);
        obs_blk[got] = bus.block;
        st++;
      end else begin
        bus.block_ready = 1'b0;
      end
      if (bus.msg_ready && sent < L) begin
        bus.msg_valid = 1'b1;
        bus.msg_data  = msg[sent];
        sent++;
        if (sent == L) last_cyc = cyc;
      end else begin
        bus.msg_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (bus.block_ready) begin
        got++;
        st = 0;
      end
    end
    bus.block_ready = 1'b0;
    bus.msg_valid   = 1'b0;
    chk($sformatf("nblk_L%0d", L), 512'(got), 512'(nblk));
    chk($sformatf("sent_L%0d", L), 512'(sent), 512'(L));
    chk($sformatf("done_L%0d", L), 512'(bus.done), 512'(1));
    chk($sformatf("idle_L%0d", L), 512'(bus.busy), 512'(0));
    if (L % 64 != 0)
      chk($sformatf("lat_L%0d", L), 512'(lat_v - last_cyc), 512'(2));
    @(negedge clk);
    chk($sformatf("done_off_L%0d", L), 512'(bus.done), 512'(0));
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.msg_length = '0; bus.msg_valid = 1'b0;
    bus.msg_data = '0; bus.block_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_blk",   bus.block, '0);
    chk("rst_busy",  512'(bus.busy), 512'(0));
    chk("rst_valid", 512'(bus.block_valid), 512'(0));
    chk("rst_mrdy",  512'(bus.msg_ready), 512'(0));
    chk("rst_last",  512'(bus.block_last), 512'(0));
    chk("rst_done",  512'(bus.done), 512'(0));
    chk("rst_lerr",  512'(bus.length_err), 512'(0));
    reset = 1'b1;
    repeat (4) @(negedge clk);

    run_msg(3, 0, 8'h61);
    chk("l3_const", obs_blk[0], {32'h61626380, 416'h0, 64'h18});
    run_msg(0, 0, 8'h00);
    chk("l0_const", obs_blk[0], {8'h80, 504'h0});
    run_msg(55, 1, 8'h10);
    chk("l55_pad", 512'(obs_blk[0][71:64]), 512'(8'h80));
    chk("l55_len", 512'(obs_blk[0][63:0]), 512'(64'h1b8));
    run_msg(56, 0, 8'h20);
    chk("l56_pad", 512'(obs_blk[0][63:0]), 512'(64'h8000000000000000));
    chk("l56_len", obs_blk[1], {448'h0, 64'h1c0});
    run_msg(64, 2, 8'h30);
    chk("l64_blk1", obs_blk[1], {8'h80, 440'h0, 64'h200});
    run_msg(100, 5, 8'h40);

    bus.start = 1'b1; bus.msg_length = 8'd120;
    @(negedge clk);
    bus.start = 1'b0;
    chk("lerr_on",   512'(bus.length_err), 512'(1));
    chk("lerr_busy", 512'(bus.busy), 512'(0));
    @(negedge clk);
    chk("lerr_off",  512'(bus.length_err), 512'(0));
    chk("lerr_idle", 512'(bus.busy), 512'(0));

    bus.start = 1'b1; bus.msg_length = 8'd20;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.msg_valid = 1'b1; bus.msg_data = 8'(8'hA0 + i);
      @(negedge clk);
    end
    bus.msg_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("abort_blk",  bus.block, '0);
    chk("abort_busy", 512'(bus.busy), 512'(0));
    chk("abort_mrdy", 512'(bus.msg_ready), 512'(0));
    chk("abort_vld",  512'(bus.block_valid), 512'(0));
    chk("abort_done", 512'(bus.done), 512'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_done", 512'(bus.done), 512'(0));
    run_msg(3, 0, 8'h61);
    chk("l3_again", obs_blk[0], {32'h61626380, 416'h0, 64'h18});

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
